// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that forwards whole messages from NUM_REQ byte requesters into the UART TX FIFO.
// Optional feature: define UART_TX_ARB_TIMEOUT_EN to force release of an owner that stops requesting.
module uart_tx_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 16,
    parameter int TIMEOUT   = 255
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 tx_en_i,
    input  logic [NUM_REQ-1:0]   req_i,
    input  logic [NUM_REQ-1:0]   last_i,
    input  logic [8*NUM_REQ-1:0] data_i,
    output logic [NUM_REQ-1:0]   ack_o,
    output logic [NUM_REQ-1:0]   grant_o,
    input  logic                 fifo_full_i,
    output logic                 fifo_wr_en_o,
    output logic [7:0]           fifo_wr_data_o,
    output logic                 busy_o,
    output logic                 timeout_o
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, XFER} state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [PW-1:0]      owner_q, owner_d;
    logic [PW-1:0]      ptr_q, ptr_d;
    logic [PW-1:0]      pick, cand;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               found;
    logic               accept;
    logic               release_msg;
    logic               force_rel;
    int                 idx;

    // Search starts just after the previous owner so every requester gets a turn.
    always_comb begin
        pick  = ptr_q;
        cand  = ptr_q;
        found = 1'b0;
        idx   = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx  = (int'(ptr_q) + i) % NUM_REQ;
            cand = PW'(idx);
            if (!found && req_i[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // A byte in the reset cycle is refused so the requester retries it after reset.
    assign accept      = (state_q == XFER) & req_i[owner_q] & ~fifo_full_i & ~rst_i;
    assign release_msg = accept & (last_i[owner_q] | (cnt_q == CW'(MAX_BURST - 1)));

    assign ack_o          = accept ? grant_q : '0;
    assign fifo_wr_en_o   = accept;
    assign fifo_wr_data_o = accept ? data_i[{owner_q, 3'b000} +: 8] : 8'h00;
    assign busy_o         = (state_q == XFER);
    assign grant_o        = grant_q;

`ifdef UART_TX_ARB_TIMEOUT_EN
    logic [7:0] idle_q, idle_d;

    always_comb begin
        idle_d    = idle_q;
        force_rel = 1'b0;
        if (state_q != XFER || req_i[owner_q]) begin
            idle_d = 8'd0;
        end else if (idle_q == 8'(TIMEOUT - 1)) begin
            force_rel = 1'b1;
            idle_d    = 8'd0;
        end else begin
            idle_d = idle_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) idle_q <= 8'd0;
        else       idle_q <= idle_d;
    end

    assign timeout_o = force_rel & ~rst_i;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
    assign force_rel      = 1'b0;
    assign timeout_o      = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (tx_en_i && found) begin
                    state_d       = XFER;
                    owner_d       = pick;
                    grant_d       = '0;
                    grant_d[pick] = 1'b1;
                    cnt_d         = '0;
                end
            end
            XFER: begin
                if (release_msg || force_rel) begin
                    state_d = IDLE;
                    grant_d = '0;
                    ptr_d   = owner_q;
                    cnt_d   = '0;
                end else if (accept) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            owner_q <= '0;
            ptr_q   <= PW'(NUM_REQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomised scoreboard bench for uart_tx_arbiter against a message-level arbitration model.
// Mirrors the UART_TX_ARB_TIMEOUT_EN build option in its model.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

    localparam int NR   = 4;
    localparam int MB   = 16;
    localparam int TOUT = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            txEn;
    logic            full;
    logic [NR-1:0]   req;
    logic [NR-1:0]   last;
    logic [8*NR-1:0] dataBus;
    logic [NR-1:0]   ack;
    logic [NR-1:0]   grant;
    logic            wrEn;
    logic [7:0]      wrData;
    logic            busy;
    logic            timeoutOut;

    uart_tx_arbiter #(.NUM_REQ(NR), .MAX_BURST(MB), .TIMEOUT(TOUT)) dut (
        .clk_i(clk), .rst_i(rst), .tx_en_i(txEn), .req_i(req), .last_i(last),
        .data_i(dataBus), .ack_o(ack), .grant_o(grant), .fifo_full_i(full),
        .fifo_wr_en_o(wrEn), .fifo_wr_data_o(wrData), .busy_o(busy), .timeout_o(timeoutOut)
    );

    always #5 clk = ~clk;

    int assertCount = 0;
    int failCount   = 0;

    logic [8:0] pend [NR][$];
    logic [7:0] expQ [NR][$];
    bit   [NR-1:0] reqHeld;
    logic [NR-1:0] ackCap;
    int   startProb;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic driveReqs();
        logic [8:0] head;
        for (int k = 0; k < NR; k++) begin
            if (pend[k].size() == 0) begin
                reqHeld[k]        = 1'b0;
                req[k]            = 1'b0;
                last[k]           = 1'($urandom);
                dataBus[k*8 +: 8] = 8'($urandom);
            end else begin
                head = pend[k][0];
                if (!reqHeld[k] && ($urandom_range(99) < startProb)) reqHeld[k] = 1'b1;
                req[k]            = reqHeld[k];
                last[k]           = reqHeld[k] ? head[8] : 1'($urandom);
                dataBus[k*8 +: 8] = reqHeld[k] ? head[7:0] : 8'($urandom);
            end
        end
    endtask

    task automatic applyStimulus(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            ackCap = ack;
            @(posedge clk);
            #1;
            for (int k = 0; k < NR; k++) begin
                if (ackCap[k] && pend[k].size() > 0) begin
                    void'(pend[k].pop_front());
                    reqHeld[k] = 1'b0;
                end
            end
            driveReqs();
        end
    endtask

    task automatic queueMsg(input int k, input int n, input bit withLast, input int base);
        logic [7:0] d;
        for (int i = 0; i < n; i++) begin
            d = (base < 0) ? 8'($urandom) : 8'(base + i);
            pend[k].push_back({withLast && (i == n - 1), d});
            expQ[k].push_back(d);
        end
    endtask

    task automatic waitPend(input int k, input int target, input string name);
        int cyc = 0;
        while (pend[k].size() > target && cyc < 60) begin
            applyStimulus(1);
            cyc++;
        end
        checkOutput(name, 32'(pend[k].size() > target), 32'd0);
    endtask

    // Reference model: one owner at a time, round-robin from the last owner, release on last or burst cap.
    int  mOwner = -1;
    int  mPtr   = NR - 1;
    int  mCnt   = 0;
    int  mIdle  = 0;
    bit  armed  = 1'b0;

    always @(negedge clk) begin
        logic [NR-1:0] expGrant;
        logic [NR-1:0] expAck;
        logic          expAcc;
        logic          expTo;
        logic [7:0]    expData;
        bit            rel;
        bit            got;
        int            j;

        expGrant = '0;
        if (mOwner >= 0) expGrant[mOwner] = 1'b1;
        expAcc = (mOwner >= 0) && req[mOwner] && !full && !rst;
        expAck = expAcc ? expGrant : '0;
        expTo  = 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
        if (mOwner >= 0 && !rst && !req[mOwner] && mIdle == TOUT - 1) expTo = 1'b1;
`endif
        expData = 8'h00;
        if (expAcc) begin
            if (expQ[mOwner].size() == 0) checkOutput("scoreboardUnderflow", 32'd1, 32'd0);
            else expData = expQ[mOwner].pop_front();
        end

        if (armed) begin
            checkOutput("grant", 32'(grant), 32'(expGrant));
            checkOutput("busy", 32'(busy), 32'(expGrant != '0));
            checkOutput("ack", 32'(ack), 32'(expAck));
            checkOutput("wrEn", 32'(wrEn), 32'(expAcc));
            checkOutput("wrData", 32'(wrData), 32'(expData));
            checkOutput("timeout", 32'(timeoutOut), 32'(expTo));
        end

        if (rst) begin
            mOwner = -1; mPtr = NR - 1; mCnt = 0; mIdle = 0;
            armed  = 1'b1;
        end else if (mOwner < 0) begin
            if (txEn && (req != '0)) begin
                got = 1'b0;
                for (int i = 1; i <= NR; i++) begin
                    j = (mPtr + i) % NR;
                    if (!got && req[j]) begin
                        got = 1'b1; mOwner = j; mCnt = 0; mIdle = 0;
                    end
                end
            end
        end else begin
            rel = 1'b0;
            if (expAcc) begin
                mCnt++;
                if (last[mOwner] || mCnt == MB) rel = 1'b1;
            end
`ifdef UART_TX_ARB_TIMEOUT_EN
            if (req[mOwner]) mIdle = 0;
            else begin
                mIdle++;
                if (mIdle == TOUT) rel = 1'b1;
            end
`endif
            if (rel) begin
                mPtr = mOwner; mOwner = -1; mCnt = 0; mIdle = 0;
            end
        end
    end

    initial begin
        bit stuck;
        int cyc;
        rst = 1'b1; txEn = 1'b0; full = 1'b0; req = '0; last = '0; dataBus = '0;
        reqHeld = '0; startProb = 100;
        applyStimulus(3);
        rst = 1'b0;
        applyStimulus(2);

        $display("[TB] two requesters, short messages");
        txEn = 1'b1;
        queueMsg(1, 2, 1'b1, 'h41);
        queueMsg(3, 2, 1'b1, 'h80);
        driveReqs();
        applyStimulus(10);

        $display("[TB] burst cap with competing requester, then idle owner");
        queueMsg(0, 20, 1'b0, 'h00);
        queueMsg(2, 3, 1'b1, 'hA0);
        driveReqs();
        applyStimulus(40);
        queueMsg(2, 2, 1'b1, 'hB0);
        driveReqs();
        applyStimulus(12);

        $display("[TB] reset mid-message");
        rst = 1'b1;
        applyStimulus(1);
        rst = 1'b0;
        queueMsg(0, 3, 1'b1, 'hC0);
        driveReqs();
        applyStimulus(14);

        $display("[TB] FIFO full stall");
        queueMsg(3, 6, 1'b1, 'hD0);
        driveReqs();
        waitPend(3, 3, "stallSetup");
        full = 1'b1;
        applyStimulus(5);
        full = 1'b0;
        applyStimulus(10);

        $display("[TB] tx enable dropped mid-message");
        queueMsg(1, 4, 1'b1, 'hE0);
        queueMsg(2, 3, 1'b1, 'hF0);
        driveReqs();
        waitPend(1, 2, "txEnSetup");
        txEn = 1'b0;
        applyStimulus(10);
        txEn = 1'b1;
        applyStimulus(12);

        $display("[TB] randomised traffic");
        startProb = 70;
        for (int c = 0; c < 1500; c++) begin
            for (int k = 0; k < NR; k++)
                if (pend[k].size() == 0 && $urandom_range(99) < 6)
                    queueMsg(k, int'($urandom_range(24, 1)), 1'b1, -1);
            full = ($urandom_range(99) < 25);
            txEn = ($urandom_range(99) < 93);
            rst  = ($urandom_range(999) < 3);
            driveReqs();
            applyStimulus(1);
        end

        rst = 1'b0; full = 1'b0; txEn = 1'b1; startProb = 100;
        driveReqs();
        cyc = 0;
        stuck = 1'b1;
        while (stuck && cyc < 600) begin
            stuck = 1'b0;
            for (int k = 0; k < NR; k++) if (pend[k].size() != 0) stuck = 1'b1;
            if (stuck) applyStimulus(1);
            cyc++;
        end
        checkOutput("drain", 32'(stuck), 32'd0);
        applyStimulus(3);
        for (int k = 0; k < NR; k++) checkOutput("expQEmpty", 32'(expQ[k].size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter sharing the UART transmit FIFO write port between several byte-stream requesters (e.g. register-write path, DMA path, debug path). It grants one requester at a time, holds the grant for a whole message (until a `last` byte or a burst cap), and forwards that requester's bytes into the TX FIFO under full back-pressure. It sits between the requesters and the TX FIFO that feeds the UART transmitter.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8).
- `MAX_BURST`, 16: maximum bytes per grant (1..255).
- `TIMEOUT`, 255: idle-cycle limit for the owner (only with `UART_TX_ARB_TIMEOUT_EN`).

- `clk_i` in 1: system clock; single clock domain.
- `rst_i` in 1: reset, synchronous, active-high.
- `tx_en_i` in 1: TX enable from the control register; gates new grants only.
- `req_i` in NUM_REQ: per-requester byte valid; held until acked.
- `last_i` in NUM_REQ: per-requester last byte of message, qualified by `req_i`.
- `data_i` in 8*NUM_REQ: packed bytes; requester k on `[8k+7:8k]`.
- `ack_o` out NUM_REQ: byte of requester k accepted this cycle.
- `grant_o` out NUM_REQ: one-hot current owner, registered; all-zero when idle.
- `fifo_full_i` in 1: TX FIFO full.
- `fifo_wr_en_o` out 1: FIFO write strobe.
- `fifo_wr_data_o` out 8: FIFO write data.
- `busy_o` out 1: grant held.
- `timeout_o` out 1: one-cycle pulse on forced release; constant 0 without the macro.

## Operation
- States: IDLE, XFER.
- IDLE: if `tx_en_i` and `|req_i`, pick the first requesting index in the order ptr+1, ptr+2, … (mod NUM_REQ). Register `grant_o` for that index, clear the byte counter, and go to XFER. With no request, or `tx_en_i`=0, stay in IDLE with `grant_o`=0.
- XFER, owner g:
  - `ack_o[g]` = `fifo_wr_en_o` = `req_i[g] & ~fifo_full_i`, combinational. `fifo_wr_data_o` = `data_i[g]` (mux on the registered grant).
  - `ack_o` is never asserted for any non-owner.
  - Each accepted byte increments the counter (width `$clog2(MAX_BURST+1)`).
  - Release happens on an accepted byte with `last_i[g]`=1, or on the accepted byte that brings the counter to MAX_BURST. Both together cause a single release.
  - On release: ptr←g, `grant_o`←0, state←IDLE, all on the next edge.
  - `fifo_full_i`=1: no ack, counter holds, grant holds indefinitely.
  - `req_i[g]`=0: grant holds (message lock); no release without the macro.
  - `tx_en_i` falling in XFER: the current message completes normally; no new grant follows.
- `busy_o` = (state==XFER).
- `fifo_wr_data_o` = 0 when `fifo_wr_en_o`=0.

## Timing
- Reset (synchronous, on `clk_i` edge with `rst_i`=1): state IDLE, `grant_o`=0, ptr=NUM_REQ-1 (requester 0 first), counter 0, `ack_o`=0, `fifo_wr_en_o`=0, `fifo_wr_data_o`=0, `busy_o`=0, `timeout_o`=0.
- Reset mid-message: the byte in the reset cycle is not acked; the grant is lost and the requester must retry.
- Request-to-grant: `req_i` sampled in IDLE at edge N, `grant_o` and first possible ack in cycle N+1.
- Throughput: 1 byte/cycle while granted and not full.
- Owner switch: 1 dead cycle (IDLE) between a release and the next grant.
- The FIFO write is in the same cycle as the ack, so `fifo_full_i` is always current and no overflow is possible.

## Configuration
- `UART_TX_ARB_TIMEOUT_EN` defined: in XFER, an idle counter (8 bits) increments each cycle with `req_i[g]`=0. It clears on any cycle with `req_i[g]`=1, including FIFO-full stalls.
  - When the counter reaches TIMEOUT: forced release (ptr←g, IDLE), `timeout_o`=1 for that one cycle, counter cleared.
- Not defined: no idle counter; an owner that stops requesting keeps the grant until it sends `last`; `timeout_o` is tied 0.

## Test plan
- After reset, `req_i`=4'b1010 with `tx_en_i`=1 → `grant_o`=4'b0010 next cycle. Bytes 0x41, 0x42 (last) written in order; next grant is 4'b1000 after 1 idle cycle.
- Requester 0 streams 20 bytes with no `last`, MAX_BURST=16, requester 2 also requesting → exactly 16 writes, grant passes to requester 2, then returns to 0 for the remaining 4.
- `fifo_full_i` held high 5 cycles mid-message → no `ack_o`/`fifo_wr_en_o`, grant unchanged; transfer resumes in the first not-full cycle with no byte lost or duplicated.
- `tx_en_i` dropped after 2 of 4 bytes → all 4 bytes written, then `grant_o`=0 and no new grant while other requests are pending; re-enable → grant on the next cycle.
- `rst_i` pulsed mid-message → `grant_o`=0, `busy_o`=0 next cycle; first grant afterwards goes to requester 0 if it is requesting.
- With `UART_TX_ARB_TIMEOUT_EN`, TIMEOUT=8: owner drops `req_i` for 8 cycles → `timeout_o` pulses once, grant moves to the next requester. Without the macro, the same stimulus leaves the grant held.
